sfp_seq: RTL and testbench
==========================

# sfp_seq

Sequencer that drives one `sfp` lane from the partial-sum SRAM and writes finished outputs back. For each output index it:
- clears the `sfp` accumulator,
- streams `num_acc` partial-sum words through `acc` pulses,
- applies one `relu` threshold cycle,
- writes the resulting `psum_bw` value to the output SRAM.

It sits between the psum SRAM read port, the `sfp` control/data pins and the output SRAM write port, and is kicked off by the top-level controller.

## Interface
Parameters:
- `bw`, 8, width of partial-sum words read from SRAM / `sfp_in`
- `psum_bw`, 16, width of accumulated result / threshold
- `addr_bw`, 11, SRAM address width
- `num_acc`, 9, partial sums accumulated per output (kernel positions)
- `num_out`, 64, outputs per run

Ports:
- `clk`  in  1  clock, all logic on rising edge
- `reset`  in  1  synchronous, active-low reset
- `start`  in  1  one-cycle request to begin a run; sampled only in IDLE
- `thres`  in  psum_bw  ReLU threshold, latched on accepted `start`
- `busy`  out  1  high from the cycle after accepted `start` until DONE exits
- `done`  out  1  one-cycle pulse at end of run
- `rd_en`  out  1  psum SRAM read strobe
- `rd_addr`  out  addr_bw  psum SRAM read address
- `rd_data`  in  bw  psum SRAM read data, valid exactly 1 cycle after `rd_en`
- `sfp_acc`  out  1  to `sfp` `acc`
- `sfp_relu`  out  1  to `sfp` `relu`
- `sfp_reset`  out  1  to `sfp` `reset` (active-high)
- `sfp_in`  out  bw  to `sfp` `in`; combinationally equal to `rd_data`
- `sfp_thres`  out  psum_bw  to `sfp` `thres`; latched threshold register
- `sfp_out`  in  psum_bw  from `sfp` `out`
- `wr_en`  out  1  output SRAM write strobe
- `wr_addr`  out  addr_bw  output SRAM write address (= output index)
- `wr_data`  out  psum_bw  combinationally equal to `sfp_out`
- `wr_ready`  in  1  output SRAM accepts write when high with `wr_en`

## Operation
- States: IDLE, CLEAR, READ, DRAIN, RELU, WRITE, DONE.
- IDLE: `start`=1 latches `thres`, sets output counter `o`=0, and moves to CLEAR. `start` outside IDLE is ignored.
- CLEAR (1 cycle): `sfp_reset`=1, `k`=0. Next state is READ.
- READ (`num_acc` cycles):
  - `rd_en`=1, `rd_addr` = `k*num_out + o`; `k` increments each cycle.
  - After the read with `k`=`num_acc-1`, move to DRAIN.
- Accumulate pipeline: `sfp_acc` is `rd_en` delayed by one cycle. It is therefore high on READ cycles 2..`num_acc` and on DRAIN, exactly `num_acc` pulses, each paired with that cycle's `rd_data`.
- DRAIN (1 cycle): last `sfp_acc`, `rd_en`=0. Next state is RELU.
- RELU (1 cycle): `sfp_relu`=1. Next state is WRITE.
- WRITE:
  - `wr_en`=1, `wr_addr`=`o`, `wr_data`=`sfp_out`.
  - Holds while `wr_ready`=0; `sfp` is idle (no acc/relu), so `sfp_out` is stable.
  - On `wr_ready`=1: if `o`=`num_out-1` go to DONE, else `o`++ and go to CLEAR.
- DONE (1 cycle): `done`=1, `busy`=0 next cycle, return to IDLE.
- Arithmetic: all accumulation happens in `sfp`, which sign-extends `bw` to `psum_bw` and wraps on overflow (no saturation). `sfp_seq` does no arithmetic on data.
- Address arithmetic: `k*num_out+o` is computed in `addr_bw` bits and truncates. Parameters must satisfy `num_acc*num_out <= 2^addr_bw`.

## Timing
- Reset (`reset`=0 at a rising edge) forces IDLE, counters 0, `rd_en`/`wr_en`/`sfp_acc`/`sfp_relu`/`busy`/`done`=0, `rd_addr`/`wr_addr`/`sfp_thres`=0, `sfp_reset`=1.
- `sfp_reset` is 1 in reset and CLEAR, 0 otherwise.
- Reset mid-run aborts immediately; no write is issued afterwards. A new `start` is needed after reset deasserts.
- All outputs are registered, except `sfp_in`=`rd_data` and `wr_data`=`sfp_out`.
- Latency, `start` to first `rd_en`: 2 cycles (CLEAR at +1, READ at +2).
- Cycles per output with `wr_ready` held 1: `num_acc`+4.
- Whole run: `num_out*(num_acc+4)` cycles from CLEAR entry to DONE, plus any `wr_ready` stall cycles.
- `start` asserted in the same cycle as DONE is ignored; it is accepted only in IDLE.

## Test plan
Params `num_acc`=3, `num_out`=2. psum SRAM holds addr0..5 = 5, −3, 10, 4, −20, 6.
- Basic run, `thres`=0: reads 0,2,4 then 1,3,5. Writes addr0=0 (sum −5 clipped) and addr1=7. `done` pulses 15 cycles after `start`.
- `thres`=8, same data: addr1 sum 7 < 8, so both writes are 0.
- `wr_ready` low for 3 cycles during first WRITE: `wr_en`/`wr_addr`=0/`wr_data`=0 held stable, no extra `sfp_acc`. `done` is delayed by 3 cycles.
- `start` pulsed while busy, and again in the DONE cycle: no effect, exactly 2 writes; new `start` in IDLE restarts from o=0.
- `reset`=0 during second READ phase: next cycle all strobes 0, `sfp_reset`=1, `busy`=0, no write to addr1.
- Overflow: SRAM words all 127, `num_acc`=3: `wr_data`=381 (no wrap at `psum_bw`=16). With `psum_bw`=8 the result wraps to 125.

Source files
------------

// File: rtl/sfp_seq.sv
// sfp_seq: sequencer driving one sfp lane from the partial-sum SRAM.
// Per output index: clear the accumulator, stream num_acc partial sums,
// apply one ReLU threshold cycle, then write the result to the output SRAM.
// Every output is a register loaded from next-state decode. The exceptions
// are sfp_in and wr_data, which are straight pass-throughs of SRAM/sfp data.
module sfp_seq #(
  parameter int bw      = 8,
  parameter int psum_bw = 16,
  parameter int addr_bw = 11,
  parameter int num_acc = 9,
  parameter int num_out = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [psum_bw-1:0] thres,
  output logic               busy,
  output logic               done,
  output logic               rd_en,
  output logic [addr_bw-1:0] rd_addr,
  input  logic [bw-1:0]      rd_data,
  output logic               sfp_acc,
  output logic               sfp_relu,
  output logic               sfp_reset,
  output logic [bw-1:0]      sfp_in,
  output logic [psum_bw-1:0] sfp_thres,
  input  logic [psum_bw-1:0] sfp_out,
  output logic               wr_en,
  output logic [addr_bw-1:0] wr_addr,
  output logic [psum_bw-1:0] wr_data,
  input  logic               wr_ready
);

  localparam int kw = (num_acc > 1) ? $clog2(num_acc) : 1;
  localparam int ow = (num_out > 1) ? $clog2(num_out) : 1;
  localparam logic [kw-1:0]      k_last   = kw'(num_acc - 1);
  localparam logic [ow-1:0]      o_last   = ow'(num_out - 1);
  localparam logic [addr_bw-1:0] addr_inc = addr_bw'(num_out);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_READ, S_DRAIN, S_RELU, S_WRITE, S_DONE
  } state_t;

  state_t        state_q, state_nxt;
  logic [kw-1:0] k_q, k_nxt;
  logic [ow-1:0] o_q, o_nxt;

  // Read strobe is the stage-0 valid; its one-cycle delay pairs with rd_data.
  logic                 rd_vld_p0;
  logic                 acc_vld_p1;
  logic [addr_bw-1:0]   rd_addr_p0;
  logic [addr_bw-1:0]   wr_addr_q;
  logic [psum_bw-1:0]   thres_q;
  logic                 relu_q;
  logic                 clr_q;
  logic                 wr_en_q;
  logic                 busy_q;
  logic                 done_q;

  // Next-state and counter update; k indexes kernel positions, o outputs.
  always_comb begin
    state_nxt = state_q;
    k_nxt     = k_q;
    o_nxt     = o_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_CLEAR;
          o_nxt     = '0;
        end
      end
      S_CLEAR: begin
        state_nxt = S_READ;
        k_nxt     = '0;
      end
      S_READ: begin
        if (k_q == k_last) begin
          state_nxt = S_DRAIN;
        end else begin
          k_nxt = k_q + kw'(1);
        end
      end
      S_DRAIN: state_nxt = S_RELU;
      S_RELU:  state_nxt = S_WRITE;
      S_WRITE: begin
        if (wr_ready) begin
          if (o_q == o_last) begin
            state_nxt = S_DONE;
          end else begin
            o_nxt     = o_q + ow'(1);
            state_nxt = S_CLEAR;
          end
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      o_q     <= '0;
    end else begin
      state_q <= state_nxt;
      k_q     <= k_nxt;
      o_q     <= o_nxt;
    end
  end

  // Control strobes decoded from the upcoming state so they align with it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_vld_p0  <= 1'b0;
      acc_vld_p1 <= 1'b0;
      relu_q     <= 1'b0;
      clr_q      <= 1'b1;
      wr_en_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      rd_vld_p0  <= (state_nxt == S_READ);
      acc_vld_p1 <= rd_vld_p0;
      relu_q     <= (state_nxt == S_RELU);
      clr_q      <= (state_nxt == S_CLEAR);
      wr_en_q    <= (state_nxt == S_WRITE);
      busy_q     <= (state_nxt != S_IDLE);
      done_q     <= (state_nxt == S_DONE);
    end
  end

  // Addresses and threshold. The read address starts at o and steps by
  // num_out, which gives k*num_out+o truncated to addr_bw without a multiply.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_addr_p0 <= '0;
      wr_addr_q  <= '0;
      thres_q    <= '0;
    end else begin
      if (state_nxt == S_READ) begin
        if (state_q == S_CLEAR) begin
          rd_addr_p0 <= addr_bw'(o_q);
        end else begin
          rd_addr_p0 <= rd_addr_p0 + addr_inc;
        end
      end
      wr_addr_q <= addr_bw'(o_nxt);
      if ((state_q == S_IDLE) && start) begin
        thres_q <= thres;
      end
    end
  end

  assign rd_en     = rd_vld_p0;
  assign rd_addr   = rd_addr_p0;
  assign sfp_acc   = acc_vld_p1;
  assign sfp_relu  = relu_q;
  assign sfp_reset = clr_q;
  assign sfp_in    = rd_data;
  assign sfp_thres = thres_q;
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = sfp_out;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_sfp_seq.sv
// Bench for sfp_seq: SRAM and sfp lane models around the DUT, a queue-based
// scoreboard of expected reads/writes, and directed plus random runs.
`timescale 1ns/1ps
module tb_sfp_seq;
  localparam int BW = 8, PBW = 16, ABW = 11, NACC = 3, NOUT = 2;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           start = 1'b0;
  logic [PBW-1:0] thres = '0;
  logic           busy, done, rd_en;
  logic [ABW-1:0] rd_addr;
  logic [BW-1:0]  rd_data = '0;
  logic           sfp_acc, sfp_relu, sfp_reset;
  logic [BW-1:0]  sfp_in;
  logic [PBW-1:0] sfp_thres, sfp_out;
  logic           wr_en;
  logic [ABW-1:0] wr_addr;
  logic [PBW-1:0] wr_data;
  logic           wr_ready = 1'b1;

  logic [BW-1:0]  mem [0:(1<<ABW)-1];
  logic [PBW-1:0] acc_m = '0;

  int             rd_q[$];
  int             wa_q[$];
  logic [PBW-1:0] wd_q[$];

  int checks = 0;
  int errors = 0;
  int rdy_mode = 0;
  int stall_left = 0;

  sfp_seq #(.bw(BW), .psum_bw(PBW), .addr_bw(ABW), .num_acc(NACC), .num_out(NOUT)) dut (
    .clk(clk), .reset(reset), .start(start), .thres(thres), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .sfp_acc(sfp_acc),
    .sfp_relu(sfp_relu), .sfp_reset(sfp_reset), .sfp_in(sfp_in), .sfp_thres(sfp_thres),
    .sfp_out(sfp_out), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(wr_ready)
  );

  always #5 clk = ~clk;

  // psum SRAM: data one cycle after the read strobe.
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  // sfp lane: sign-extending wrapping accumulator with ReLU threshold.
  always @(posedge clk) begin
    if (sfp_reset) acc_m <= '0;
    else if (sfp_acc) acc_m <= acc_m + {{(PBW-BW){sfp_in[BW-1]}}, sfp_in};
    else if (sfp_relu && ($signed(acc_m) < $signed(sfp_thres))) acc_m <= '0;
  end
  assign sfp_out = acc_m;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: event not expected / not seen", nm);
  endtask

  // Reference: sum of sign-extended words wrapped to PBW, then threshold.
  function automatic logic [PBW-1:0] ref_out(input int o, input logic [PBW-1:0] th);
    int s;
    logic signed [PBW-1:0] r;
    s = 0;
    for (int k = 0; k < NACC; k++) s += int'($signed(mem[(k*NOUT+o) % (1<<ABW)]));
    r = PBW'(s);
    if (r < $signed(th)) return '0;
    return r;
  endfunction

  task automatic expect_run(input logic [PBW-1:0] th);
    for (int o = 0; o < NOUT; o++) begin
      for (int k = 0; k < NACC; k++) rd_q.push_back((k*NOUT+o) % (1<<ABW));
      wa_q.push_back(o);
      wd_q.push_back(ref_out(o, th));
    end
  endtask

  // wr_ready driver: always ready, random, or a fixed stall on first write.
  initial forever begin
    @(posedge clk); #1;
    case (rdy_mode)
      1: wr_ready = ($urandom % 3) != 0;
      2: begin
        if (stall_left > 0 && wr_en) begin
          wr_ready = 1'b0;
          stall_left--;
        end else wr_ready = 1'b1;
      end
      default: wr_ready = 1'b1;
    endcase
  end

  // Monitor: pops expectations whenever the DUT reads or completes a write.
  logic           stall_prev = 1'b0;
  logic [ABW-1:0] hold_a = '0;
  logic [PBW-1:0] hold_d = '0;
  int             acc_cnt = 0;
  initial forever begin
    @(negedge clk);
    if (!reset) begin
      stall_prev = 1'b0;
      acc_cnt = 0;
    end else begin
      if (sfp_reset) acc_cnt = 0;
      else if (sfp_acc) acc_cnt++;
      if (rd_en) begin
        if (rd_q.size() == 0) fail_now("unexpected_read");
        else chk("rd_addr", rd_addr, rd_q.pop_front());
      end
      if (wr_en) begin
        if (stall_prev) begin
          chk("stall_wr_addr", wr_addr, hold_a);
          chk("stall_wr_data", wr_data, hold_d);
        end
        if (wr_ready) begin
          stall_prev = 1'b0;
          chk("acc_pulses", acc_cnt, NACC);
          if (wa_q.size() == 0) fail_now("unexpected_write");
          else begin
            chk("wr_addr", wr_addr, wa_q.pop_front());
            chk("wr_data", wr_data, wd_q.pop_front());
          end
        end else begin
          stall_prev = 1'b1;
          hold_a = wr_addr;
          hold_d = wr_data;
        end
      end else stall_prev = 1'b0;
    end
  end

  task automatic run(input logic [PBW-1:0] th, input int exp_lat, input bit ign_busy,
                     input bit ign_done);
    int cyc;
    int first_rd;
    bit seen;
    expect_run(th);
    @(posedge clk); #1;
    thres = th;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    thres = PBW'($urandom);
    cyc = 0;
    first_rd = -1;
    seen = 1'b0;
    while (cyc < 400 && !seen) begin
      @(negedge clk);
      cyc++;
      if (rd_en && first_rd < 0) first_rd = cyc;
      if (cyc == 1) chk("busy_after_start", busy, 1);
      if (ign_busy && cyc == 5) begin
        start = 1'b1;
        thres = 16'h7fff;
      end
      if (ign_busy && cyc == 6) start = 1'b0;
      if (done) seen = 1'b1;
    end
    if (!seen) fail_now("done_timeout");
    else begin
      chk("first_rd_latency", first_rd, 2);
      if (exp_lat > 0) chk("done_latency", cyc, exp_lat);
      chk("busy_in_done", busy, 1);
      if (ign_done) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("busy_after_done", busy, 0);
      chk("done_one_cycle", done, 0);
      if (ign_done) begin
        repeat (3) @(negedge clk);
        chk("start_in_done_ignored", busy, 0);
      end
    end
    chk("queues_drained", rd_q.size() + wa_q.size(), 0);
  endtask

  task automatic run_reset(input logic [PBW-1:0] th);
    int cyc;
    bit busy_seen;
    expect_run(th);
    @(posedge clk); #1;
    thres = th;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    reset = 1'b0;
    @(posedge clk); #1;
    chk("rst_rd_en", rd_en, 0);
    chk("rst_sfp_acc", sfp_acc, 0);
    chk("rst_sfp_relu", sfp_relu, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sfp_reset", sfp_reset, 1);
    chk("rst_writes_left", wa_q.size(), 1);
    rd_q.delete();
    wa_q.delete();
    wd_q.delete();
    reset = 1'b1;
    busy_seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (busy) busy_seen = 1'b1;
    end
    chk("idle_after_reset", busy_seen, 0);
  endtask

  initial begin
    for (int i = 0; i < (1<<ABW); i++) mem[i] = '0;
    reset = 1'b0;
    thres = 16'h1234;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rd_en", rd_en, 0);
    chk("reset_wr_en", wr_en, 0);
    chk("reset_sfp_acc", sfp_acc, 0);
    chk("reset_sfp_relu", sfp_relu, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_rd_addr", rd_addr, 0);
    chk("reset_wr_addr", wr_addr, 0);
    chk("reset_sfp_thres", sfp_thres, 0);
    chk("reset_sfp_reset", sfp_reset, 1);
    reset = 1'b1;

    mem[0] = 8'd5;
    mem[1] = 8'hfd;
    mem[2] = 8'd10;
    mem[3] = 8'd4;
    mem[4] = 8'hec;
    mem[5] = 8'd6;
    chk("ref_out0_thres0", ref_out(0, 16'd0), 0);
    chk("ref_out1_thres0", ref_out(1, 16'd0), 7);

    rdy_mode = 0;
    run(16'd0, 15, 1'b0, 1'b0);
    run(16'd8, 15, 1'b0, 1'b0);

    rdy_mode = 2;
    stall_left = 3;
    run(16'd0, 18, 1'b0, 1'b0);
    rdy_mode = 0;

    run(16'd0, 15, 1'b1, 1'b1);

    run_reset(16'd0);
    run(16'd0, 15, 1'b0, 1'b0);

    for (int i = 0; i < 6; i++) mem[i] = 8'd127;
    chk("ref_overflow", ref_out(1, 16'd0), 381);
    run(16'd0, 15, 1'b0, 1'b0);

    rdy_mode = 1;
    for (int it = 0; it < 8; it++) begin
      for (int i = 0; i < 6; i++) mem[i] = BW'($urandom);
      run(PBW'(int'($urandom_range(0, 600)) - 300), -1, 1'b0, 1'b0);
    end
    rdy_mode = 0;

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
